set_row_arbiter_n: RTL and testbench

N-requester successor of the two-port (mask-upload / readout) set-row decoder. It arbitrates row-set requests from N_REQ sources (exposure, readout, calibration, ...) onto the single shared row decoder bus. It sequences DEC_SEL/DEC_EN with programmable per-phase timing and returns a per-source done pulse. Generalises the 2-source fixed-port version with parametrised source count and address width, selectable fixed-priority or round-robin arbitration, lossless request queuing and an out-of-range row guard.

---
 rtl/set_row_arbiter_n_pkg.sv | 29 ++
 rtl/rr_prio_arbiter.sv | 44 ++++
 rtl/set_row_arbiter_n.sv | 193 +++++++++++++++++++
 tb/tb_set_row_arbiter_n.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/set_row_arbiter_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : set_row_arbiter_n_pkg
// Description : Shared types and helpers for the N-source set-row arbiter:
//               sequencer state encoding, arbitration mode constants and the
//               grant-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package set_row_arbiter_n_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SEL   = 3'd2,
        ST_EN    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of a source index; never narrower than one bit
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_prio_arbiter
// Description : Combinational N-way picker. Fixed mode returns the lowest
//               pending index; round-robin mode returns the first pending
//               index at or above the pointer, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_arbiter
    import set_row_arbiter_n_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int GRANT_W = 2
) (
    input  logic [N_REQ-1:0]   pending,
    input  logic [GRANT_W-1:0] pointer,
    input  logic               mode,
    output logic               valid,
    output logic [GRANT_W-1:0] index
);

    // Scan from the start position and keep the first pending hit
    always_comb begin
        int start;
        valid = 1'b0;
        index = '0;
        start = (mode == MODE_RR) ? int'(pointer) : 0;
        for (int k = 0; k < N_REQ; k++) begin
            int                 j;
            logic [GRANT_W-1:0] j_idx;
            j = start + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            j_idx = GRANT_W'(j);
            if (!valid && pending[j_idx]) begin
                valid = 1'b1;
                index = j_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/set_row_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : set_row_arbiter_n
// Description : Arbitrates N_REQ row-set requests onto one shared row decoder
//               bus and sequences DEC_SEL/DEC_EN with shadowed per-phase
//               timing, returning a per-source done pulse. Addresses at or
//               above num_row skip the decoder and complete with rowadd_err.
// Revision    : 1.0 - initial release
// ============================================================================
module set_row_arbiter_n
    import set_row_arbiter_n_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 10,
    parameter int TIME_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          set_row,
    input  logic [N_REQ*ADDR_W-1:0]   rowadd_in,
    input  logic                      rr_mode,
    input  logic [ADDR_W-1:0]         num_row,
    input  logic [TIME_W-1:0]         T_SEL_D,
    input  logic [TIME_W-1:0]         T_EN_D,
    input  logic [TIME_W-1:0]         T_EN_W,
    input  logic [TIME_W-1:0]         T_SEL_H,
    input  logic [TIME_W-1:0]         T_DONE_W,
    output logic [ADDR_W-1:0]         ROWADD_op,
    output logic                      DEC_SEL,
    output logic                      DEC_EN,
    output logic [N_REQ-1:0]          set_row_done,
    output logic                      busy,
    output logic [grant_w(N_REQ)-1:0] grant_id,
    output logic                      rowadd_err
);

    localparam int GRANT_W = grant_w(N_REQ);

    state_t              r_state;
    state_t              w_next;
    logic [N_REQ-1:0]    r_pending;
    logic [GRANT_W-1:0]  r_ptr;
    logic [GRANT_W-1:0]  r_gid;
    logic [GRANT_W-1:0]  w_idx;
    logic                w_valid;
    logic                w_grant;
    logic                r_gnt;
    logic                r_oor;
    logic                r_err;
    logic [N_REQ-1:0]    w_gnt_mask;
    logic [ADDR_W-1:0]   w_addr_arr [N_REQ];
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rowadd;
    logic [TIME_W-1:0]   r_t_sel_d;
    logic [TIME_W-1:0]   r_t_en_d;
    logic [TIME_W-1:0]   r_t_en_w;
    logic [TIME_W-1:0]   r_t_sel_h;
    logic [TIME_W-1:0]   r_t_done_w;
    logic [TIME_W-1:0]   r_cnt;
    logic [TIME_W-1:0]   w_cnt_load;

    // Phase length max(T,1) expressed as a down-counter preload
    function automatic logic [TIME_W-1:0] ph_len(input logic [TIME_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = rowadd_in[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    rr_prio_arbiter #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_arb (
        .pending (r_pending),
        .pointer (r_ptr),
        .mode    (rr_mode),
        .valid   (w_valid),
        .index   (w_idx)
    );

    // A grant is issued from IDLE one cycle before the sequence starts
    assign w_grant = (r_state == ST_IDLE) && !r_gnt && w_valid;

    // One-hot clear mask for the source being granted
    always_comb begin
        w_gnt_mask = '0;
        if (w_grant) begin
            w_gnt_mask[w_idx] = 1'b1;
        end
    end

    // Next-state logic: each timed phase advances when its counter hits zero
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_gnt)          w_next = r_oor ? ST_DONE : ST_SETUP;
            ST_SETUP: if (r_cnt == '0)    w_next = ST_SEL;
            ST_SEL:   if (r_cnt == '0)    w_next = ST_EN;
            ST_EN:    if (r_cnt == '0)    w_next = ST_HOLD;
            ST_HOLD:  if (r_cnt == '0)    w_next = ST_DONE;
            ST_DONE:  if (r_cnt == '0)    w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    // Counter preload for the phase being entered, from shadowed timing
    always_comb begin
        w_cnt_load = '0;
        case (w_next)
            ST_SETUP: w_cnt_load = ph_len(r_t_sel_d);
            ST_SEL:   w_cnt_load = ph_len(r_t_en_d);
            ST_EN:    w_cnt_load = ph_len(r_t_en_w);
            ST_HOLD:  w_cnt_load = ph_len(r_t_sel_h);
            ST_DONE:  w_cnt_load = ph_len(r_t_done_w);
            default:  w_cnt_load = '0;
        endcase
    end

    // State register, request queue, grant capture and phase counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_ptr      <= '0;
            r_gid      <= '0;
            r_gnt      <= 1'b0;
            r_oor      <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_rowadd   <= '0;
            r_t_sel_d  <= '0;
            r_t_en_d   <= '0;
            r_t_en_w   <= '0;
            r_t_sel_h  <= '0;
            r_t_done_w <= '0;
            r_cnt      <= '0;
        end else begin
            r_state   <= w_next;
            // A new request in the grant cycle wins over the clear
            r_pending <= (r_pending & ~w_gnt_mask) | set_row;
            r_gnt     <= w_grant;
            if (w_grant) begin
                r_gid      <= w_idx;
                r_addr     <= w_addr_arr[w_idx];
                r_oor      <= (w_addr_arr[w_idx] >= num_row);
                r_t_sel_d  <= T_SEL_D;
                r_t_en_d   <= T_EN_D;
                r_t_en_w   <= T_EN_W;
                r_t_sel_h  <= T_SEL_H;
                r_t_done_w <= T_DONE_W;
                if (int'(w_idx) == N_REQ - 1) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_idx + 1'b1;
                end
            end
            // Out-of-range grants leave the decoder address untouched
            if ((r_state == ST_IDLE) && (w_next == ST_SETUP)) begin
                r_rowadd <= r_addr;
            end
            r_err <= (r_state == ST_IDLE) && (w_next == ST_DONE);
            if (w_next != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Decoder strobes and status decoded from the current state
    always_comb begin
        DEC_SEL      = 1'b0;
        DEC_EN       = 1'b0;
        set_row_done = '0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_SEL:  DEC_SEL = 1'b1;
            ST_EN:   begin DEC_SEL = 1'b1; DEC_EN = 1'b1; end
            ST_HOLD: DEC_SEL = 1'b1;
            ST_DONE: set_row_done[r_gid] = 1'b1;
            default: ;
        endcase
    end

    assign ROWADD_op  = r_rowadd;
    assign grant_id   = r_gid;
    assign rowadd_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_set_row_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_row_arbiter_n
// Description : Directed self-checking bench for set_row_arbiter_n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_row_arbiter_n;

    localparam int N_REQ  = 3;
    localparam int ADDR_W = 10;
    localparam int TIME_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        set_row;
    logic [N_REQ*ADDR_W-1:0] rowadd_in;
    logic                    rr_mode;
    logic [ADDR_W-1:0]       num_row;
    logic [TIME_W-1:0]       T_SEL_D, T_EN_D, T_EN_W, T_SEL_H, T_DONE_W;
    logic [ADDR_W-1:0]       ROWADD_op;
    logic                    DEC_SEL, DEC_EN, busy, rowadd_err;
    logic [N_REQ-1:0]        set_row_done;
    logic [1:0]              grant_id;

    int n_checks = 0;
    int n_errors = 0;

    set_row_arbiter_n #(
        .N_REQ (N_REQ), .ADDR_W (ADDR_W), .TIME_W (TIME_W)
    ) dut (
        .clk (clk), .rst (rst), .set_row (set_row), .rowadd_in (rowadd_in),
        .rr_mode (rr_mode), .num_row (num_row),
        .T_SEL_D (T_SEL_D), .T_EN_D (T_EN_D), .T_EN_W (T_EN_W),
        .T_SEL_H (T_SEL_H), .T_DONE_W (T_DONE_W),
        .ROWADD_op (ROWADD_op), .DEC_SEL (DEC_SEL), .DEC_EN (DEC_EN),
        .set_row_done (set_row_done), .busy (busy), .grant_id (grant_id),
        .rowadd_err (rowadd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_timing(input int sd, input int ed, input int ew, input int sh, input int dw);
        T_SEL_D  = TIME_W'(sd);
        T_EN_D   = TIME_W'(ed);
        T_EN_W   = TIME_W'(ew);
        T_SEL_H  = TIME_W'(sh);
        T_DONE_W = TIME_W'(dw);
    endtask

    task automatic pulse_req(input logic [N_REQ-1:0] req);
        set_row = req;
        step();
        set_row = '0;
    endtask

    // Waits for the next operation and tallies its phase lengths
    task automatic observe_op(output int gid, output int sel_c, output int en_c,
                              output int done_c, output int err_c, output int to);
        int w;
        gid = -1; sel_c = 0; en_c = 0; done_c = 0; err_c = 0; to = 0;
        w = 0;
        while (!busy && w < 60) begin step(); w++; end
        if (!busy) begin to = 1; return; end
        w = 0;
        while (busy && w < 300) begin
            if (DEC_SEL) sel_c++;
            if (DEC_EN) en_c++;
            if (rowadd_err) err_c++;
            if (set_row_done != '0) begin
                done_c++;
                for (int b = 0; b < N_REQ; b++) if (set_row_done[b]) gid = b;
            end
            step();
            w++;
        end
        if (busy) to = 1;
    endtask

    task automatic wait_en(output int to);
        int w;
        w = 0;
        to = 0;
        while (!DEC_EN && w < 60) begin step(); w++; end
        if (!DEC_EN) to = 1;
    endtask

    initial begin
        int gid, sc, ec, dc, rc, to;
        int exp_order[3];
        rst = 1'b1; set_row = '0; rowadd_in = '0; rr_mode = 1'b0;
        num_row = 10'd1023;
        set_timing(4, 1, 2, 4, 4);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_rowadd", 32'(ROWADD_op), 0);
        chk("rst_sel", 32'(DEC_SEL), 0);
        chk("rst_en", 32'(DEC_EN), 0);
        chk("rst_done", 32'(set_row_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_err", 32'(rowadd_err), 0);

        // Single request, cycle-exact timeline; address change mid-op ignored
        rowadd_in[1*ADDR_W +: ADDR_W] = 10'd37;
        pulse_req(3'b010);
        chk("t1_busy_c0", 32'(busy), 0);
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 3) rowadd_in[1*ADDR_W +: ADDR_W] = 10'd5;
            chk($sformatf("t1_rowadd_c%0d", c), 32'(ROWADD_op), (c >= 2) ? 37 : 0);
            chk($sformatf("t1_sel_c%0d", c), 32'(DEC_SEL), (c >= 6 && c <= 12) ? 1 : 0);
            chk($sformatf("t1_en_c%0d", c), 32'(DEC_EN), (c >= 7 && c <= 8) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", c), 32'(set_row_done), (c >= 13 && c <= 16) ? 2 : 0);
            chk($sformatf("t1_busy_c%0d", c), 32'(busy), (c >= 2 && c <= 16) ? 1 : 0);
            chk($sformatf("t1_gid_c%0d", c), 32'(grant_id), 1);
        end

        // Fixed priority: all three pending -> 0,1,2
        set_timing(1, 1, 1, 1, 1);
        rowadd_in[0 +: ADDR_W] = 10'd1;
        rowadd_in[1*ADDR_W +: ADDR_W] = 10'd2;
        rowadd_in[2*ADDR_W +: ADDR_W] = 10'd3;
        pulse_req(3'b111);
        for (int k = 0; k < 3; k++) begin
            observe_op(gid, sc, ec, dc, rc, to);
            chk($sformatf("fix_to_%0d", k), 32'(to), 0);
            chk($sformatf("fix_gid_%0d", k), 32'(gid), 32'(k));
            chk($sformatf("fix_sel_%0d", k), 32'(sc), 3);
            chk($sformatf("fix_done_%0d", k), 32'(dc), 1);
        end

        // Grant source 0 alone so the pointer moves to 1, then round-robin
        pulse_req(3'b001);
        observe_op(gid, sc, ec, dc, rc, to);
        chk("rr_pre_gid", 32'(gid), 0);
        rr_mode = 1'b1;
        pulse_req(3'b111);
        exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 0;
        for (int k = 0; k < 3; k++) begin
            observe_op(gid, sc, ec, dc, rc, to);
            chk($sformatf("rr_to_%0d", k), 32'(to), 0);
            chk($sformatf("rr_gid_%0d", k), 32'(gid), 32'(exp_order[k]));
            chk($sformatf("rr_en_%0d", k), 32'(ec), 1);
        end
        rr_mode = 1'b0;

        // Re-request by the granted source during EN is not lost
        set_timing(4, 1, 2, 4, 4);
        rowadd_in[2*ADDR_W +: ADDR_W] = 10'd100;
        pulse_req(3'b100);
        wait_en(to);
        chk("rq_wait_en", 32'(to), 0);
        pulse_req(3'b100);
        begin
            int w;
            w = 0;
            while (busy && w < 60) begin step(); w++; end
            chk("rq_first_end", 32'(busy), 0);
        end
        observe_op(gid, sc, ec, dc, rc, to);
        chk("rq_to", 32'(to), 0);
        chk("rq_gid", 32'(gid), 2);
        chk("rq_sel", 32'(sc), 7);
        chk("rq_en", 32'(ec), 2);
        chk("rq_done", 32'(dc), 4);
        chk("rq_rowadd", 32'(ROWADD_op), 100);
        repeat (5) step();
        chk("rq_idle_after", 32'(busy), 0);

        // Out-of-range address: no strobes, single error pulse, address held
        num_row = 10'd10;
        rowadd_in[0 +: ADDR_W] = 10'd12;
        pulse_req(3'b001);
        observe_op(gid, sc, ec, dc, rc, to);
        chk("oor_to", 32'(to), 0);
        chk("oor_gid", 32'(gid), 0);
        chk("oor_sel", 32'(sc), 0);
        chk("oor_en", 32'(ec), 0);
        chk("oor_done", 32'(dc), 4);
        chk("oor_err", 32'(rc), 1);
        chk("oor_rowadd", 32'(ROWADD_op), 100);
        num_row = 10'd1023;

        // All timing inputs zero: every phase one cycle
        set_timing(0, 0, 0, 0, 0);
        rowadd_in[1*ADDR_W +: ADDR_W] = 10'd7;
        pulse_req(3'b010);
        observe_op(gid, sc, ec, dc, rc, to);
        chk("zero_to", 32'(to), 0);
        chk("zero_gid", 32'(gid), 1);
        chk("zero_sel", 32'(sc), 3);
        chk("zero_en", 32'(ec), 1);
        chk("zero_done", 32'(dc), 1);
        chk("zero_rowadd", 32'(ROWADD_op), 7);

        // Reset during EN with two requests pending
        set_timing(4, 1, 2, 4, 4);
        rowadd_in[0 +: ADDR_W] = 10'd3;
        pulse_req(3'b001);
        wait_en(to);
        chk("rs_wait_en", 32'(to), 0);
        pulse_req(3'b110);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_sel", 32'(DEC_SEL), 0);
        chk("rs_en", 32'(DEC_EN), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_rowadd", 32'(ROWADD_op), 0);
        chk("rs_done", 32'(set_row_done), 0);
        chk("rs_gid", 32'(grant_id), 0);
        for (int c = 1; c <= 10; c++) begin
            step();
            chk($sformatf("rs_busy_after_%0d", c), 32'(busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
